// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares one single-ported 64-bit synchronous data memory between two
//   requesters (port 0 = pipeline MEM stage, port 1 = debug/loader).
//   At most one access is issued per cycle. Contested cycles are resolved
//   round-robin. Byte enables and write-lane steering come from size and
//   offset. Load data is sign- or zero-extended on the response cycle.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   mN_req/we/addr/size  per-port request; fields are held stable until mN_gnt
//   mN_unsigned/wdata    load zero-extend select, right-aligned store data
//   mN_gnt               request accepted this cycle (combinational)
//   mN_rvalid/rdata/err  one-cycle response pulse, one cycle after mN_gnt
//   mem_en/we/idx/be     memory strobe, write, doubleword index, byte enables
//   mem_wdata            lane-steered store data
//   mem_rdata            read data, valid the cycle after mem_en
module dmem_port_arbiter #(
  parameter int ADDR_W    = 12,
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [1:0]        m0_size,
  input  logic              m0_unsigned,
  input  logic [63:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [63:0]       m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [1:0]        m1_size,
  input  logic              m1_unsigned,
  input  logic [63:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [63:0]       m1_rdata,
  output logic              m1_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-4:0] mem_idx,
  output logic [7:0]        mem_be,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata
);

  // Arbitration state: rr_ptr names the requester that wins the next tie.
  logic rr_ptr_q, rr_ptr_d;

  // Response register, captured at grant time.
  logic       rsp_vld_q;
  logic       rsp_port_q;
  logic [1:0] rsp_size_q;
  logic       rsp_uns_q;
  logic [2:0] rsp_off_q;
  logic       rsp_we_q;
  logic       rsp_err_q;

  logic              any_gnt, win;
  logic              sel_we, sel_uns, misal, issue;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_size;
  logic [63:0]       sel_wdata;
  logic [2:0]        off;
  logic [7:0]        size_mask;
  logic [63:0]       ld_sh, ld_ext, rsp_data;

  // Grant. Held in reset so nothing is accepted while rst is high.
  always_comb begin
    any_gnt  = 1'b0;
    win      = 1'b0;
    rr_ptr_d = rr_ptr_q;
    if (!rst) begin
      if (m0_req && m1_req) begin
        any_gnt  = 1'b1;
        win      = rr_ptr_q;
        rr_ptr_d = ~rr_ptr_q;   // the loser of this tie wins the next one
      end else if (m0_req) begin
        any_gnt = 1'b1;
        win     = 1'b0;
      end else if (m1_req) begin
        any_gnt = 1'b1;
        win     = 1'b1;
      end
    end
  end

  assign m0_gnt = any_gnt & ~win;
  assign m1_gnt = any_gnt &  win;

  // Winner's request fields.
  assign sel_we    = win ? m1_we       : m0_we;
  assign sel_uns   = win ? m1_unsigned : m0_unsigned;
  assign sel_addr  = win ? m1_addr     : m0_addr;
  assign sel_size  = win ? m1_size     : m0_size;
  assign sel_wdata = win ? m1_wdata    : m0_wdata;
  assign off       = sel_addr[2:0];

  always_comb begin
    misal     = 1'b0;
    size_mask = 8'h01;
    case (sel_size)
      2'b00: begin misal = 1'b0;          size_mask = 8'h01; end
      2'b01: begin misal = sel_addr[0];   size_mask = 8'h03; end
      2'b10: begin misal = |sel_addr[1:0]; size_mask = 8'h0F; end
      default: begin misal = |off;        size_mask = 8'hFF; end
    endcase
  end

  // A misaligned access is granted but never reaches the memory.
  assign issue     = any_gnt & ~misal;
  assign mem_en    = issue;
  assign mem_we    = issue & sel_we;
  assign mem_idx   = issue ? sel_addr[ADDR_W-1:3] : '0;
  assign mem_be    = issue ? (size_mask << off) : 8'h00;
  assign mem_wdata = issue ? (sel_wdata << {off, 3'b000}) : 64'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= PRIO_INIT;
      rsp_vld_q  <= 1'b0;
      rsp_port_q <= 1'b0;
      rsp_size_q <= 2'b00;
      rsp_uns_q  <= 1'b0;
      rsp_off_q  <= 3'b000;
      rsp_we_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rsp_vld_q  <= any_gnt;
      rsp_port_q <= win;
      rsp_size_q <= sel_size;
      rsp_uns_q  <= sel_uns;
      rsp_off_q  <= off;
      rsp_we_q   <= sel_we;
      rsp_err_q  <= misal;
    end
  end

  // Load alignment and extension on the response cycle.
  assign ld_sh = mem_rdata >> {rsp_off_q, 3'b000};

  always_comb begin
    ld_ext = ld_sh;
    case (rsp_size_q)
      2'b00:   ld_ext = {{56{ld_sh[7]  & ~rsp_uns_q}}, ld_sh[7:0]};
      2'b01:   ld_ext = {{48{ld_sh[15] & ~rsp_uns_q}}, ld_sh[15:0]};
      2'b10:   ld_ext = {{32{ld_sh[31] & ~rsp_uns_q}}, ld_sh[31:0]};
      default: ld_ext = ld_sh;
    endcase
  end

  // Stores and errored accesses return zero.
  assign rsp_data = (rsp_vld_q && !rsp_we_q && !rsp_err_q) ? ld_ext : 64'h0;

  assign m0_rvalid = rsp_vld_q & ~rsp_port_q;
  assign m1_rvalid = rsp_vld_q &  rsp_port_q;
  assign m0_rdata  = m0_rvalid ? rsp_data : 64'h0;
  assign m1_rdata  = m1_rvalid ? rsp_data : 64'h0;
  assign m0_err    = m0_rvalid & rsp_err_q;
  assign m1_err    = m1_rvalid & rsp_err_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: an issue monitor predicts grants
// and responses from a byte-level memory model, a response monitor pops
// and compares whenever the DUT should or does present a response.
module tb_dmem_port_arbiter;
  localparam int ADDR_W    = 12;
  localparam bit PRIO_INIT = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]             req = '0, we = '0, uns = '0;
  logic [1:0][ADDR_W-1:0] addr = '0;
  logic [1:0][1:0]        size = '0;
  logic [1:0][63:0]       wdata = '0;
  logic                   m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [63:0]            m0_rdata, m1_rdata;
  logic                   mem_en, mem_we;
  logic [ADDR_W-4:0]      mem_idx;
  logic [7:0]             mem_be;
  logic [63:0]            mem_wdata;
  logic [63:0]            mem_rdata = '0;

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .PRIO_INIT(PRIO_INIT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_size(size[0]),
    .m0_unsigned(uns[0]), .m0_wdata(wdata[0]), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_size(size[1]),
    .m1_unsigned(uns[1]), .m1_wdata(wdata[1]), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_idx(mem_idx), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int checks = 0, errors = 0;
  longint cyc = 0;
  int ties = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Synchronous SRAM driven only by the DUT's memory interface.
  logic [63:0] sram [512];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int i = 0; i < 8; i++)
          if (mem_be[i]) sram[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end else begin
        mem_rdata <= sram[mem_idx];
      end
    end
  end

  // Reference memory as a plain byte array, updated from request fields.
  logic [7:0] ref_mem [4096];

  task automatic set_dw(input int i, input logic [63:0] d);
    sram[i] = d;
    for (int b = 0; b < 8; b++) ref_mem[8*i + b] = d[8*b +: 8];
  endtask

  typedef struct {
    int          port;
    logic [63:0] rdata;
    logic        err;
    longint      due;
  } exp_t;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Issue monitor: predicts the grant and, for the winner, the memory
  // access and the response it must eventually see.
  always @(negedge clk) begin : issue_mon
    int p, bytes, off;
    logic [1:0]  eg;
    logic [7:0]  ebe;
    logic [63:0] val;
    logic        mis;
    if (rst) begin
      ties = 0;
    end else begin
      eg = req;
      if (req == 2'b11) begin
        eg = '0;
        eg[(int'(PRIO_INIT) + ties) % 2] = 1'b1;
        ties++;
      end
      chk("gnt", {62'h0, m1_gnt, m0_gnt}, {62'h0, eg});
      if (eg != 2'b00) begin
        p     = eg[1] ? 1 : 0;
        bytes = 1 << size[p];
        off   = int'(addr[p]) % 8;
        mis   = (int'(addr[p]) % bytes) != 0;
        if (mis) begin
          chk("mem_en_misal", {63'h0, mem_en}, 64'h0);
          sb.push_back('{p, 64'h0, 1'b1, cyc + 1});
        end else begin
          ebe = '0;
          for (int i = 0; i < 8; i++) if (i >= off && i < off + bytes) ebe[i] = 1'b1;
          chk("mem_en", {63'h0, mem_en}, 64'h1);
          chk("mem_we", {63'h0, mem_we}, {63'h0, we[p]});
          chk("mem_idx", {55'h0, mem_idx}, 64'(int'(addr[p]) / 8));
          chk("mem_be", {56'h0, mem_be}, {56'h0, ebe});
          if (we[p]) chk("mem_wdata", mem_wdata, wdata[p] << (8 * off));
          val = '0;
          if (we[p]) begin
            for (int j = 0; j < bytes; j++) ref_mem[int'(addr[p]) + j] = wdata[p][8*j +: 8];
          end else begin
            for (int j = 0; j < bytes; j++) val[8*j +: 8] = ref_mem[int'(addr[p]) + j];
            if (!uns[p] && bytes < 8 && val[8*bytes-1]) val = val | (~64'h0 << (8 * bytes));
          end
          sb.push_back('{p, val, 1'b0, cyc + 1});
        end
      end else begin
        chk("mem_en_idle", {63'h0, mem_en}, 64'h0);
      end
    end
  end

  // Response monitor: the front entry is due exactly one cycle after issue.
  always @(negedge clk) begin : rsp_mon
    logic [1:0] ev;
    logic       due;
    exp_t       e;
    if (!rst) begin
      ev  = '0;
      due = (sb.size() > 0) && (sb[0].due <= cyc);
      if (due) ev[sb[0].port] = 1'b1;
      chk("rvalid", {62'h0, m1_rvalid, m0_rvalid}, {62'h0, ev});
      if (due) begin
        e = sb.pop_front();
        chk("rdata", e.port ? m1_rdata : m0_rdata, e.rdata);
        chk("err", {63'h0, e.port ? m1_err : m0_err}, {63'h0, e.err});
      end
    end
  end

  // Directed single access on an otherwise idle bus.
  task automatic dir(input string name, input int p, input logic w, input int a,
                     input logic [1:0] sz, input logic u, input logic [63:0] wd,
                     input logic [7:0] ebe, input int eidx,
                     input logic [63:0] erd, input logic eerr);
    @(posedge clk); #1;
    req[p] = 1'b1; we[p] = w; addr[p] = ADDR_W'(a); size[p] = sz; uns[p] = u; wdata[p] = wd;
    @(negedge clk);
    chk({name, "_gnt"}, {63'h0, p ? m1_gnt : m0_gnt}, 64'h1);
    chk({name, "_en"}, {63'h0, mem_en}, {63'h0, ~eerr});
    if (!eerr) begin
      chk({name, "_be"}, {56'h0, mem_be}, {56'h0, ebe});
      chk({name, "_idx"}, {55'h0, mem_idx}, 64'(eidx));
      if (w) chk({name, "_wlane"}, {56'h0, mem_wdata[8*(a%8) +: 8]}, {56'h0, wd[7:0]});
    end
    @(posedge clk); #1;
    req[p] = 1'b0;
    @(negedge clk);
    chk({name, "_rvalid"}, {63'h0, p ? m1_rvalid : m0_rvalid}, 64'h1);
    chk({name, "_rdata"}, p ? m1_rdata : m0_rdata, erd);
    chk({name, "_err"}, {63'h0, p ? m1_err : m0_err}, {63'h0, eerr});
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [1:0] g;
    int hold [2];
    for (int i = 0; i < 512; i++) set_dw(i, {$urandom, $urandom});
    set_dw(0, 64'h1234567812345678);
    set_dw(1, 64'h9ABCDEF09ABCDEF0);

    // Reset: requests present but nothing may be granted or issued.
    req = 2'b11; addr[0] = 12'h000; addr[1] = 12'h008; size[0] = 2'd2; size[1] = 2'd2;
    repeat (2) @(negedge clk);
    chk("rst_gnt", {62'h0, m1_gnt, m0_gnt}, 64'h0);
    chk("rst_mem_en", {62'h0, mem_we, mem_en}, 64'h0);
    chk("rst_mem_be", {56'h0, mem_be}, 64'h0);
    chk("rst_mem_wdata", mem_wdata, 64'h0);
    chk("rst_rvalid", {60'h0, m1_err, m0_err, m1_rvalid, m0_rvalid}, 64'h0);
    chk("rst_rdata", m0_rdata | m1_rdata, 64'h0);

    // Contested for 4 cycles: alternate starting from PRIO_INIT.
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("tie_order", {62'h0, m1_gnt, m0_gnt}, (i % 2) ? 64'h2 : 64'h1);
    end
    // Reset right after a grant: its response must never appear.
    #1 rst = 1'b1; req = '0; sb.delete();
    repeat (2) @(negedge clk);
    chk("rst_drop_a", {62'h0, m1_rvalid, m0_rvalid}, 64'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_drop_b", {62'h0, m1_rvalid, m0_rvalid}, 64'h0);

    dir("lw0",  0, 1'b0, 'h0,  2'd2, 1'b0, 64'h0,  8'h0F, 0, 64'h0000000012345678, 1'b0);
    dir("lh8",  0, 1'b0, 'h8,  2'd1, 1'b0, 64'h0,  8'h03, 1, 64'hFFFFFFFFFFFFDEF0, 1'b0);
    dir("lhu8", 0, 1'b0, 'h8,  2'd1, 1'b1, 64'h0,  8'h03, 1, 64'h000000000000DEF0, 1'b0);
    dir("lbF",  1, 1'b0, 'hF,  2'd0, 1'b0, 64'h0,  8'h80, 1, 64'hFFFFFFFFFFFFFF9A, 1'b0);
    dir("lbuF", 1, 1'b0, 'hF,  2'd0, 1'b1, 64'h0,  8'h80, 1, 64'h000000000000009A, 1'b0);
    dir("sb13", 0, 1'b1, 'h13, 2'd0, 1'b0, 64'hAB, 8'h08, 2, 64'h0, 1'b0);
    dir("lw6",  0, 1'b0, 'h6,  2'd2, 1'b0, 64'h0,  8'h00, 0, 64'h0, 1'b1);
    dir("ld10", 1, 1'b0, 'h10, 2'd3, 1'b0, 64'h0,  8'hFF, 2,
        {sram[2][63:32], sram[2][31:24], sram[2][23:0]}, 1'b0);

    // Randomized traffic: each port holds its request until granted.
    hold[0] = 0; hold[1] = 0;
    g = 2'b11;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (g[p] || !req[p]) begin
          req[p]   = ($urandom_range(0, 3) != 0);
          we[p]    = 1'($urandom_range(0, 1));
          addr[p]  = ADDR_W'($urandom_range(0, 63));
          size[p]  = 2'($urandom_range(0, 3));
          uns[p]   = 1'($urandom_range(0, 1));
          wdata[p] = {$urandom, $urandom};
          hold[p]  = 0;
        end else if (++hold[p] > 4) begin
          chk("starve", 64'(hold[p]), 64'h1);
          req[p] = 1'b0;
          hold[p] = 0;
        end
      end
      @(negedge clk);
      g = {m1_gnt, m0_gnt};
    end
    @(posedge clk); #1 req = '0;
    repeat (3) @(negedge clk);
    chk("sb_drain", 64'(sb.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
